// File: rtl/division_4bits_core.sv
// Sequential restoring divider: one shift-subtract step per clock,
// signed quotient/remainder rebuilt from magnitudes and sign bits.
module division_4bits_core #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             div_start,
    input  logic [WIDTH-1:0] dividend_mag,
    input  logic [WIDTH-1:0] divisor_mag,
    input  logic             dividend_sign,
    input  logic             divisor_sign,
    output logic             busy,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic             div_finish
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] dvd;
    logic [WIDTH-1:0] dsr;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] q;
    logic [CW-1:0]    cnt;
    logic             neg_q;
    logic             neg_r;
    logic             zf;

    logic [WIDTH-1:0] rem_sh;
    logic [WIDTH:0]   trial;

    // Shifted partial remainder and the trial subtraction, one bit wider
    // so the borrow tells us whether the divisor fits.
    always_comb begin
        rem_sh = {rem[WIDTH-2:0], dvd[WIDTH-1]};
        trial  = {1'b0, rem_sh} - {1'b0, dsr};
    end

    // Control FSM with registered datapath and outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            dvd         <= '0;
            dsr         <= '0;
            rem         <= '0;
            q           <= '0;
            cnt         <= '0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            zf          <= 1'b0;
            busy        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            div_finish  <= 1'b0;
        end else begin
            div_finish <= 1'b0;
            unique case (state)
                IDLE: begin
                    // A start coinciding with the finish pulse is dropped.
                    if (div_start && !div_finish) begin
                        dvd         <= dividend_mag;
                        dsr         <= divisor_mag;
                        neg_q       <= dividend_sign ^ divisor_sign;
                        neg_r       <= dividend_sign;
                        rem         <= '0;
                        q           <= '0;
                        cnt         <= '0;
                        busy        <= 1'b1;
                        zf          <= (divisor_mag == '0);
                        div_by_zero <= (divisor_mag == '0);
                        state       <= (divisor_mag == '0) ? FIX : RUN;
                    end
                end
                RUN: begin
                    dvd <= {dvd[WIDTH-2:0], 1'b0};
                    if (!trial[WIDTH]) begin
                        rem <= trial[WIDTH-1:0];
                        q   <= {q[WIDTH-2:0], 1'b1};
                    end else begin
                        rem <= rem_sh;
                        q   <= {q[WIDTH-2:0], 1'b0};
                    end
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(WIDTH - 1)) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    if (zf) begin
                        quotient    <= '0;
                        remainder   <= '0;
                        div_by_zero <= 1'b1;
                    end else begin
                        quotient  <= neg_q ? (~q + 1'b1) : q;
                        remainder <= neg_r ? (~rem + 1'b1) : rem;
                    end
                    div_finish <= 1'b1;
                    busy       <= 1'b0;
                    state      <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
